// File: rtl/mc_controller.sv
//------------------------------------------------------------------------------
// Module      : mc_controller
// Description : Multicycle control FSM sequencing fetch/decode/execute/memory/
//               writeback for the CR16-style 16-bit datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_controller #(
  parameter int WIDTH = 16,
  parameter int PSRL  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] INSTR,
  input  logic [PSRL-1:0]  PSR_IN,
  input  logic             MEM_RDY,
  output logic             PC_S,
  output logic             MEM_S,
  output logic [1:0]       WD_S,
  output logic [1:0]       ALUA_S,
  output logic [1:0]       ALUB_S,
  output logic             INSTR_EN,
  output logic             ALU_OUT_EN,
  output logic             MEM_REG_EN,
  output logic             PC_EN,
  output logic             PSR_EN,
  output logic             SE_SIGN,
  output logic             REG_WR,
  output logic             MEM_WR,
  output logic             ALU_ADD,
  output logic [3:0]       STATE
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ALU_R  = 4'd2,
    S_ALU_I  = 4'd3,
    S_WB     = 4'd4,
    S_LD     = 4'd5,
    S_LDWB   = 4'd6,
    S_ST     = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9,
    S_PCINC  = 4'd10,
    S_PCWR   = 4'd11
  } state_t;

  state_t r_state;

  logic [3:0] w_op, w_cond, w_ext;
  logic       w_flag_n, w_flag_z, w_flag_f, w_flag_l, w_flag_c;
  logic       w_r_alu, w_r_arith, w_i_alu, w_i_arith;
  logic       w_is_mov, w_is_movi, w_cond_true;
  logic       w_unused_imm;

  assign w_op   = INSTR[15:12];
  assign w_cond = INSTR[11:8];
  assign w_ext  = INSTR[7:4];
  assign w_unused_imm = ^INSTR[3:0];

  assign {w_flag_n, w_flag_z, w_flag_f, w_flag_l, w_flag_c} = PSR_IN[4:0];

  // Arithmetic (ADD/SUB/CMP) forms update flags and use a sign-extended immediate.
  assign w_r_arith = (w_op == 4'b0000) && (w_ext inside {4'b0101, 4'b1001, 4'b1011});
  assign w_r_alu   = w_r_arith || ((w_op == 4'b0000) && (w_ext inside {4'b0001, 4'b0010, 4'b0011}));
  assign w_i_arith = w_op inside {4'b0101, 4'b1001, 4'b1011};
  assign w_i_alu   = w_i_arith || (w_op inside {4'b0001, 4'b0010, 4'b0011});
  assign w_is_mov  = (w_op == 4'b0000) && (w_ext == 4'b1101);
  assign w_is_movi = (w_op == 4'b1101);

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      4'b0000: w_cond_true = w_flag_z;
      4'b0001: w_cond_true = !w_flag_z;
      4'b0010: w_cond_true = w_flag_c;
      4'b0011: w_cond_true = !w_flag_c;
      4'b0100: w_cond_true = w_flag_l;
      4'b0101: w_cond_true = !w_flag_l;
      4'b0110: w_cond_true = w_flag_n;
      4'b0111: w_cond_true = !w_flag_n;
      4'b1000: w_cond_true = w_flag_f;
      4'b1001: w_cond_true = !w_flag_f;
      4'b1010: w_cond_true = !w_flag_l && !w_flag_z;
      4'b1011: w_cond_true = w_flag_l || w_flag_z;
      4'b1100: w_cond_true = !w_flag_n && !w_flag_z;
      4'b1101: w_cond_true = w_flag_n || w_flag_z;
      4'b1110: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= MEM_RDY ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (w_r_alu)                                     r_state <= S_ALU_R;
          else if (w_is_mov || w_is_movi)                  r_state <= S_WB;
          else if (w_i_alu)                                r_state <= S_ALU_I;
          else if (w_op == 4'b0100 && w_ext == 4'b0000)    r_state <= S_LD;
          else if (w_op == 4'b0100 && w_ext == 4'b0100)    r_state <= S_ST;
          else if (w_op == 4'b0100 && w_ext == 4'b1100)    r_state <= S_JMP;
          else if (w_op == 4'b1100)                        r_state <= S_BR;
          else                                             r_state <= S_PCINC;
        end
        S_ALU_R:  r_state <= (w_ext == 4'b1011) ? S_PCINC : S_WB;
        S_ALU_I:  r_state <= (w_op == 4'b1011) ? S_PCINC : S_WB;
        S_WB:     r_state <= S_PCINC;
        S_LD:     r_state <= MEM_RDY ? S_LDWB : S_LD;
        S_LDWB:   r_state <= S_PCINC;
        S_ST:     r_state <= MEM_RDY ? S_PCINC : S_ST;
        S_BR:     r_state <= w_cond_true ? S_PCWR : S_PCINC;
        S_JMP:    r_state <= w_cond_true ? S_FETCH : S_PCINC;
        S_PCINC:  r_state <= S_PCWR;
        S_PCWR:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Gating on reset makes the strobes (notably MEM_WR) drop the instant reset asserts.
  always_comb begin
    PC_S       = 1'b0;
    MEM_S      = 1'b0;
    WD_S       = 2'b00;
    ALUA_S     = 2'b00;
    ALUB_S     = 2'b00;
    INSTR_EN   = 1'b0;
    ALU_OUT_EN = 1'b0;
    MEM_REG_EN = 1'b0;
    PC_EN      = 1'b0;
    PSR_EN     = 1'b0;
    SE_SIGN    = 1'b0;
    REG_WR     = 1'b0;
    MEM_WR     = 1'b0;
    ALU_ADD    = 1'b0;
    STATE      = reset ? r_state : 4'd0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          MEM_S    = 1'b1;
          INSTR_EN = MEM_RDY;
        end
        S_ALU_R: begin
          ALU_OUT_EN = 1'b1;
          PSR_EN     = w_r_arith;
        end
        S_ALU_I: begin
          ALUA_S     = 2'b10;
          ALU_OUT_EN = 1'b1;
          SE_SIGN    = w_i_arith;
          PSR_EN     = w_i_arith;
        end
        S_WB: begin
          REG_WR = 1'b1;
          WD_S   = w_is_movi ? 2'b00 : (w_is_mov ? 2'b01 : 2'b11);
        end
        S_LD:   MEM_REG_EN = MEM_RDY;
        S_LDWB: begin
          WD_S   = 2'b10;
          REG_WR = 1'b1;
        end
        S_ST:   MEM_WR = 1'b1;
        S_BR: begin
          if (w_cond_true) begin
            ALUA_S     = 2'b01;
            ALUB_S     = 2'b01;
            SE_SIGN    = 1'b1;
            ALU_ADD    = 1'b1;
            ALU_OUT_EN = 1'b1;
          end
        end
        S_JMP:  PC_EN = w_cond_true;
        S_PCINC: begin
          ALUA_S     = 2'b01;
          ALUB_S     = 2'b10;
          ALU_ADD    = 1'b1;
          ALU_OUT_EN = 1'b1;
        end
        S_PCWR: begin
          PC_S  = 1'b1;
          PC_EN = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
